tdc_packetizer: RTL and testbench
=================================

TDC_PACKETIZER -- requirements
Module: tdc_packetizer

Interface
REQ-001 Parameter DATA_W, default 256: data beat width; matches DMA bus.
REQ-002 Parameter FIFO_DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-003 Parameter LEN_W, default 16: width of the packet-length field.
REQ-004 clk_capt  in  1  capture-domain clock; all logic is on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 cfg_enable  in  1  1 = accept and stream TDC words; 0 = stop accepting and close the open packet.
REQ-007 cfg_pkt_len  in  LEN_W  beats per packet; 0 is treated as 1.
REQ-008 S_AVST_VALID  in  1  packed TDC word valid; upstream never stalls.
REQ-009 S_AVST_DATA  in  DATA_W  packed TDC word.
REQ-010 S_AVST_READY  out  1  advisory: FIFO not full; registered; feeds the pulse-generator backpressure path.
REQ-011 M_AVST_VALID, M_AVST_DATA[DATA_W], M_AVST_SOP, M_AVST_EOP  out  Avalon-ST source to the DC FIFO.
REQ-012 M_AVST_READY  in  1  sink ready; ready latency 0.
REQ-013 drop_count  out  32  count of words dropped; saturates at 0xFFFF_FFFF.
REQ-014 overflow  out  1  sticky; set on the first drop; cleared only by reset.

Function
REQ-015 Push: S_AVST_VALID & cfg_enable & (not full | pop in the same cycle).
REQ-016 When the FIFO is full and a pop occurs in the same cycle, the incoming word is accepted.
REQ-017 Drop: S_AVST_VALID & cfg_enable & full & no pop; on a drop, drop_count increments by 1 (saturating) and overflow is set.
REQ-018 When cfg_enable is 0, S_AVST_VALID is ignored and does not count as a drop.
REQ-019 Latency: a word pushed at edge N is presented on M_AVST_DATA after edge N+1 at the earliest.
REQ-020 Output valid, data, SOP and EOP are registered and hold stable while M_AVST_VALID & !M_AVST_READY.
REQ-021 A beat transfers on M_AVST_VALID & M_AVST_READY; the beat counter advances only on a transfer.
REQ-022 State IDLE: no packet open.
  - If cfg_enable & FIFO non-empty, go to STREAM.
  - Latch pkt_len = max(cfg_pkt_len, 1).
  - Beat counter = 0.
REQ-023 State STREAM: present FIFO head words.
  - SOP is asserted on beat 0.
  - EOP is asserted on beat pkt_len-1.
  - After the EOP transfer, go to IDLE; a new length is latched on the next packet.
REQ-024 In STREAM, if cfg_enable falls and the FIFO becomes empty before EOP, go to PAD.
REQ-025 State PAD: emit PAD_WORD beats, each with M_AVST_VALID=1, until the EOP beat transfers, then go to IDLE.
  - Every packet always ends with EOP.
REQ-026 In PAD, any words left in the FIFO are sent before pad beats; PAD starts only when the FIFO is empty.
REQ-027 A one-beat packet (pkt_len=1) asserts SOP and EOP on the same beat.
REQ-028 A change to cfg_pkt_len mid-packet has no effect until the next SOP.
REQ-029 The read and write pointers wrap modulo FIFO_DEPTH.
  - Full/empty come from a count register of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-030 On reset: state=IDLE, FIFO empty, beat counter=0, drop_count=0, overflow=0.
REQ-031 On reset: M_AVST_VALID=0, SOP=0, EOP=0, M_AVST_DATA=0, S_AVST_READY=0.
  - S_AVST_READY is 1 from the first cycle after reset.
REQ-032 Reset mid-packet discards the FIFO contents and the open packet with no EOP.
  - The DC FIFO side is reset by the same system reset.

Structure
REQ-033 A shared package tdc_pkg holds:
  - the state enum (IDLE, STREAM, PAD);
  - PAD_WORD = {DATA_W/32{32'hDEAD_BEEF}};
  - a DATA_W default constant.
REQ-034 One sub-module, tdc_sync_fifo: single-clock FIFO with DATA_W and FIFO_DEPTH parameters, push/pop/full/empty/count.
  - The packetizer FSM and counters live in tdc_packetizer.

Verification
REQ-035 cfg_pkt_len=4, enable, 8 consecutive input words, READY=1 -> two packets; SOP on beats 0 and 4; EOP on beats 3 and 7; data in order.
REQ-036 FIFO_DEPTH=4, READY=0, 6 input words -> 4 stored, drop_count=2, overflow=1, S_AVST_READY=0; after READY=1, the 4 words are output in order.
REQ-037 Full FIFO, READY=1 and input valid in the same cycle -> word accepted, no drop.
REQ-038 cfg_pkt_len=5, 2 words, then enable=0 -> beats: W0 (SOP), W1, PAD, PAD, PAD (EOP); then IDLE.
REQ-039 cfg_pkt_len=0 -> every beat has SOP=EOP=1; random READY stalls -> outputs stable during stalls.
REQ-040 Reset asserted in the middle of a packet -> next cycle all outputs are 0 and counters cleared; the next packet starts with SOP.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC packetizer slice.
//   pkt_state_t : packetizer FSM states (IDLE, STREAM, PAD)
//   DATA_W_DEF  : default data beat width, matching the DMA bus
//   PAD_WORD    : filler beat used to close a packet when input runs dry
package tdc_pkg;

   localparam int DATA_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      PAD    = 2'd2
   } pkt_state_t;

   localparam logic [DATA_W_DEF-1:0] PAD_WORD = {(DATA_W_DEF/32){32'hDEAD_BEEF}};

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO holding packed TDC words.
//   clk_capt, reset   : clock, synchronous active-high reset (pointers/count only)
//   push, wr_data     : write request and data; ignored when full unless popping
//   pop               : remove the head entry; ignored when empty
//   head, head_next   : current head entry and the one behind it (look-ahead)
//   full, empty, count: occupancy status
module tdc_sync_fifo
   import tdc_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk_capt,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         pop,
   output logic [DATA_W-1:0]            head,
   output logic [DATA_W-1:0]            head_next,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_nx;
   logic              wr_en;
   logic              rd_en;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign rd_en     = pop && !empty;
   // A write into a full FIFO is legal when the head leaves in the same cycle.
   assign wr_en     = push && (!full || rd_en);
   // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH on their own.
   assign rd_ptr_nx = rd_ptr + PTR_W'(1);
   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_ptr_nx];

   always_ff @(posedge clk_capt) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr_nx;
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_ff @(posedge clk_capt) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/tdc_packetizer.sv
// Packs a never-stalling stream of TDC words into fixed-length Avalon-ST
// packets for the DC FIFO feeding the DMA.
//   clk_capt, reset          : capture clock, synchronous active-high reset
//   cfg_enable               : accept/stream words; dropping it closes the open packet
//   cfg_pkt_len              : beats per packet (0 behaves as 1), latched per packet
//   S_AVST_VALID/DATA        : input words (no backpressure possible)
//   S_AVST_READY             : registered "FIFO not full" hint
//   M_AVST_VALID/DATA/SOP/EOP: registered Avalon-ST source, M_AVST_READY latency 0
//   drop_count, overflow     : saturating drop counter and sticky drop flag
module tdc_packetizer
   import tdc_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic              clk_capt,
   input  logic              reset,
   input  logic              cfg_enable,
   input  logic [LEN_W-1:0]  cfg_pkt_len,
   input  logic              S_AVST_VALID,
   input  logic [DATA_W-1:0] S_AVST_DATA,
   output logic              S_AVST_READY,
   output logic              M_AVST_VALID,
   output logic [DATA_W-1:0] M_AVST_DATA,
   output logic              M_AVST_SOP,
   output logic              M_AVST_EOP,
   input  logic              M_AVST_READY,
   output logic [31:0]       drop_count,
   output logic              overflow
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_W-1:0] PAD_BEAT = {(DATA_W/32){PAD_WORD[31:0]}};

   pkt_state_t        state;
   pkt_state_t        state_nx;
   logic [LEN_W-1:0]  pkt_len;
   logic [LEN_W-1:0]  beat;
   logic [LEN_W:0]    load_idx;
   logic              out_is_word;
   logic              xfer;
   logic              out_free;
   logic              pop;
   logic              push;
   logic              drop;
   logic              avail;
   logic              can_load;
   logic              load_word;
   logic              load_pad;
   logic              latch_len;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  count_nx;
   logic [DATA_W-1:0] fifo_head;
   logic [DATA_W-1:0] fifo_head_next;

   tdc_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_capt  (clk_capt),
      .reset     (reset),
      .push      (push),
      .wr_data   (S_AVST_DATA),
      .pop       (pop),
      .head      (fifo_head),
      .head_next (fifo_head_next),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The output register mirrors the FIFO head: a word stays counted in the
   // FIFO while it is presented and is popped only when it transfers. This
   // keeps the buffer capacity at exactly FIFO_DEPTH words.
   assign xfer     = M_AVST_VALID && M_AVST_READY;
   assign out_free = !M_AVST_VALID || M_AVST_READY;
   assign pop      = xfer && out_is_word;
   assign push     = S_AVST_VALID && cfg_enable && (!fifo_full || pop);
   assign drop     = S_AVST_VALID && cfg_enable && fifo_full && !pop;
   assign count_nx = fifo_count + CNT_W'(push) - CNT_W'(pop);

   // Index of the beat that would be loaded now: one past the transferring beat.
   assign load_idx = {1'b0, beat} + {{LEN_W{1'b0}}, xfer};
   assign can_load = out_free && (load_idx < {1'b0, pkt_len});
   // When the presented head is leaving, the next word sits one slot behind it.
   assign avail    = pop ? (fifo_count > CNT_W'(1)) : !fifo_empty;

   always_comb begin
      state_nx  = state;
      load_word = 1'b0;
      load_pad  = 1'b0;
      latch_len = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_enable && !fifo_empty) begin
               state_nx  = STREAM;
               latch_len = 1'b1;
            end
         end
         STREAM: begin
            if (xfer && M_AVST_EOP) begin
               state_nx = IDLE;
            end else if (can_load && avail) begin
               load_word = 1'b1;
            end else if (!avail && !cfg_enable) begin
               state_nx = PAD;
            end
         end
         PAD: begin
            if (xfer && M_AVST_EOP) begin
               state_nx = IDLE;
            end else if (can_load) begin
               // Leftover words always go out ahead of filler.
               if (avail) load_word = 1'b1;
               else       load_pad  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_capt) begin
      if (reset) begin
         state   <= IDLE;
         pkt_len <= LEN_W'(1);
         beat    <= '0;
      end else begin
         state <= state_nx;
         if (latch_len) begin
            pkt_len <= (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
            beat    <= '0;
         end else if (xfer) begin
            beat <= M_AVST_EOP ? '0 : beat + LEN_W'(1);
         end
      end
   end

   // Output register: only reloaded when empty or its beat is transferring.
   always_ff @(posedge clk_capt) begin
      if (reset) begin
         M_AVST_VALID <= 1'b0;
         M_AVST_DATA  <= '0;
         M_AVST_SOP   <= 1'b0;
         M_AVST_EOP   <= 1'b0;
         out_is_word  <= 1'b0;
      end else if (out_free) begin
         M_AVST_VALID <= load_word || load_pad;
         out_is_word  <= load_word;
         M_AVST_SOP   <= (load_word || load_pad) && (load_idx == '0);
         M_AVST_EOP   <= (load_word || load_pad) &&
                         (load_idx == ({1'b0, pkt_len} - (LEN_W+1)'(1)));
         if (load_word)     M_AVST_DATA <= pop ? fifo_head_next : fifo_head;
         else if (load_pad) M_AVST_DATA <= PAD_BEAT;
      end
   end

   always_ff @(posedge clk_capt) begin
      if (reset) begin
         drop_count   <= '0;
         overflow     <= 1'b0;
         S_AVST_READY <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
         end
         S_AVST_READY <= (count_nx != CNT_W'(FIFO_DEPTH));
      end
   end

endmodule

// File: tb/tb_tdc_packetizer.sv
// Self-checking bench for tdc_packetizer: directed scenarios plus randomized
// traffic, checked against a word-queue reference model of the packet rules.
module tb_tdc_packetizer;

   localparam int DW    = 256;
   localparam int DEPTH = 4;
   localparam int LW    = 16;
   localparam logic [DW-1:0] PADW = {8{32'hDEAD_BEEF}};

   logic          clk_capt = 1'b0;
   logic          reset;
   logic          cfg_enable;
   logic [LW-1:0] cfg_pkt_len;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_sop;
   logic          m_eop;
   logic          m_ready;
   logic [31:0]   drop_count;
   logic          overflow;

   always #5 clk_capt = ~clk_capt;

   tdc_packetizer #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (LW)
   ) dut (
      .clk_capt     (clk_capt),
      .reset        (reset),
      .cfg_enable   (cfg_enable),
      .cfg_pkt_len  (cfg_pkt_len),
      .S_AVST_VALID (s_valid),
      .S_AVST_DATA  (s_data),
      .S_AVST_READY (s_ready),
      .M_AVST_VALID (m_valid),
      .M_AVST_DATA  (m_data),
      .M_AVST_SOP   (m_sop),
      .M_AVST_EOP   (m_eop),
      .M_AVST_READY (m_ready),
      .drop_count   (drop_count),
      .overflow     (overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: words held by the packetizer (buffered or on display).
   logic [DW-1:0] q[$];
   int            idx     = 0;
   int            cur_len = 1;
   logic [31:0]   drop_exp = '0;
   logic          ovf_exp  = 1'b0;
   logic          rdy_exp  = 1'b0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] sv_data;
   logic          sv_sop;
   logic          sv_eop;

   typedef struct {
      bit sop;
      bit eop;
      bit pad;
   } beat_t;
   beat_t log_q[$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rword();
      logic [DW-1:0] w = '0;
      for (int i = 0; i < DW/32; i++) w = {w[DW-33:0], 32'($urandom)};
      return w;
   endfunction

   // Evaluate the model for the coming edge, advance one clock, and return
   // to the falling edge where outputs are sampled.
   task automatic step();
      bit            xf;
      bit            pp;
      bit            acc;
      logic [DW-1:0] exp;
      if (reset) begin
         q.delete();
         idx        = 0;
         drop_exp   = '0;
         ovf_exp    = 1'b0;
         rdy_exp    = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("s_ready", s_ready, rdy_exp);
         chk("drop_count", drop_count, drop_exp);
         chk("overflow", overflow, ovf_exp);
         if (stall_prev) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, sv_data);
            chk("stall_sop", m_sop, sv_sop);
            chk("stall_eop", m_eop, sv_eop);
         end
         xf = (m_valid === 1'b1) && m_ready;
         pp = 1'b0;
         if (xf) begin
            if (idx == 0) cur_len = (cfg_pkt_len == '0) ? 1 : int'(cfg_pkt_len);
            if (q.size() > 0) begin
               exp = q[0];
               pp  = 1'b1;
            end else begin
               exp = PADW;
            end
            chk("beat_data", m_data, exp);
            chk("beat_sop", m_sop, (idx == 0));
            chk("beat_eop", m_eop, (idx == cur_len - 1));
            log_q.push_back('{sop: m_sop, eop: m_eop, pad: (m_data === PADW)});
            idx = (idx == cur_len - 1) ? 0 : idx + 1;
         end
         stall_prev = (m_valid === 1'b1) && !m_ready;
         sv_data    = m_data;
         sv_sop     = m_sop;
         sv_eop     = m_eop;
         acc = s_valid && cfg_enable && ((q.size() < DEPTH) || pp);
         if (s_valid && cfg_enable && !acc) begin
            if (drop_exp != 32'hFFFF_FFFF) drop_exp++;
            ovf_exp = 1'b1;
         end
         if (pp)  void'(q.pop_front());
         if (acc) q.push_back(s_data);
         rdy_exp = (q.size() < DEPTH);
      end
      @(posedge clk_capt);
      @(negedge clk_capt);
   endtask

   task automatic drive(input bit v, input bit en, input bit rdy);
      s_valid    = v;
      s_data     = rword();
      cfg_enable = en;
      m_ready    = rdy;
      step();
   endtask

   // Stream out everything buffered, then drop enable so any open packet is padded shut.
   task automatic flush();
      int n = 0;
      s_valid    = 1'b0;
      m_ready    = 1'b1;
      cfg_enable = 1'b1;
      while (q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      cfg_enable = 1'b0;
      while (!(idx == 0 && m_valid === 1'b0) && n < 200) begin
         step();
         n++;
      end
      chk("flush_timeout", (n < 200), 1);
   endtask

   task automatic wait_beats(input int nb);
      int n = 0;
      s_valid = 1'b0;
      while (log_q.size() < nb && n < 50) begin
         step();
         n++;
      end
      chk("wait_beats_timeout", (n < 50), 1);
   endtask

   initial begin
      reset       = 1'b1;
      cfg_enable  = 1'b0;
      cfg_pkt_len = LW'(4);
      s_valid     = 1'b0;
      s_data      = '0;
      m_ready     = 1'b0;
      @(negedge clk_capt);
      repeat (3) step();

      // Reset state
      chk("rst_valid", m_valid, 0);
      chk("rst_sop", m_sop, 0);
      chk("rst_eop", m_eop, 0);
      chk("rst_data", m_data, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      step();
      chk("ready_after_rst", s_ready, 1);

      // Length 4, 8 back-to-back words, sink always ready
      log_q.delete();
      cfg_pkt_len = LW'(4);
      for (int i = 0; i < 8; i++) drive(1, 1, 1);
      flush();
      chk("p8_count", log_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("p8_sop", log_q[i].sop, (i % 4 == 0));
         chk("p8_eop", log_q[i].eop, (i % 4 == 3));
         chk("p8_pad", log_q[i].pad, 0);
      end

      // Sink stalled, 6 words into a 4-deep buffer
      log_q.delete();
      for (int i = 0; i < 6; i++) drive(1, 1, 0);
      drive(0, 1, 0);
      chk("ovf_drop_count", drop_count, 2);
      chk("ovf_flag", overflow, 1);
      chk("ovf_s_ready", s_ready, 0);
      flush();
      chk("ovf_out_count", log_q.size(), 4);

      // Full buffer with a pop and a push in the same cycle
      log_q.delete();
      for (int i = 0; i < 4; i++) drive(1, 1, 0);
      drive(0, 1, 0);
      drive(0, 1, 0);
      drive(1, 1, 1);
      chk("fullpop_drop", drop_count, 2);
      chk("fullpop_q", q.size(), 4);
      flush();
      chk("fullpop_beats", log_q.size(), 8);
      chk("fullpop_last_pad", log_q[7].pad, 1);
      chk("fullpop_last_eop", log_q[7].eop, 1);

      // Length 5, two words then enable drops: padded close
      log_q.delete();
      cfg_pkt_len = LW'(5);
      drive(1, 1, 1);
      drive(1, 1, 1);
      flush();
      chk("pad_count", log_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("pad_sop", log_q[i].sop, (i == 0));
         chk("pad_eop", log_q[i].eop, (i == 4));
         chk("pad_kind", log_q[i].pad, (i >= 2));
      end
      drive(0, 0, 1);
      chk("pad_idle_valid", m_valid, 0);

      // Length change after SOP takes effect only on the next packet
      log_q.delete();
      cfg_pkt_len = LW'(3);
      drive(1, 1, 1);
      wait_beats(1);
      cfg_pkt_len = LW'(1);
      drive(1, 1, 1);
      drive(1, 1, 1);
      flush();
      chk("midlen_count", log_q.size(), 3);
      chk("midlen_eop0", log_q[0].eop, 0);
      chk("midlen_eop2", log_q[2].eop, 1);

      // Length 0: every beat is a single-beat packet, random sink stalls
      log_q.delete();
      cfg_pkt_len = '0;
      for (int i = 0; i < 200; i++) drive(($urandom_range(0, 3) != 0), 1, ($urandom_range(0, 2) != 0));
      flush();
      foreach (log_q[i]) chk("len0_sopeop", {log_q[i].sop, log_q[i].eop}, 2'b11);

      // Random lengths and traffic
      for (int b = 0; b < 4; b++) begin
         cfg_pkt_len = LW'($urandom_range(1, 6));
         for (int i = 0; i < 100; i++) drive(($urandom_range(0, 2) != 0), 1, ($urandom_range(0, 3) != 0));
         flush();
      end

      // Reset in the middle of a packet
      log_q.delete();
      cfg_pkt_len = LW'(4);
      drive(1, 1, 1);
      drive(1, 1, 1);
      drive(1, 1, 1);
      wait_beats(1);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_sop", m_sop, 0);
      chk("mid_rst_eop", m_eop, 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_drop", drop_count, 0);
      chk("mid_rst_ovf", overflow, 0);
      reset = 1'b0;
      log_q.delete();
      for (int i = 0; i < 4; i++) drive(1, 1, 1);
      flush();
      chk("post_rst_count", log_q.size(), 4);
      chk("post_rst_sop", log_q[0].sop, 1);
      chk("post_rst_eop", log_q[3].eop, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
